id_gen: RTL and testbench

- Generates a stream of ASCII identifier characters, one per accepted transfer, for feeding the identifier-recognizer path (id_fsm) and its testbenches.
- Each request emits a fixed pattern: a run of letters, then a run of digits, then one separator character.
- Sits upstream of any 8-bit char consumer.
- Uses a valid/ready handshake so the consumer can stall it.

---
 rtl/id_gen_pkg.sv | 19 +
 rtl/id_gen_if.sv | 12 +
 rtl/id_gen_wrap_ctr.sv | 42 ++++
 rtl/id_gen.sv | 149 ++++++++++++++
 tb/tb_id_gen.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/id_gen_pkg.sv
// id_pkg: shared constants and state encoding for the identifier generator.
//   ASCII bases for letters/digits/space, alphabet and digit moduli, and
//   the 2-bit state encoding used by id_gen.
package id_pkg;
    localparam logic [7:0] CH_a  = 8'h61;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_SP = 8'h20;

    localparam int LETTERS = 26;
    localparam int DIGITS  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALPHA = 2'd1,
        DIGIT = 2'd2,
        SEP_S = 2'd3
    } state_e;
endpackage

// File: rtl/id_gen_if.sv
// id_gen_if: 8-bit character stream with valid/ready handshake.
//   char       : current ASCII character (producer -> consumer)
//   char_valid : char is valid            (producer -> consumer)
//   char_ready : consumer accepts char    (consumer -> producer)
interface id_gen_if;
    logic [7:0] char;
    logic       char_valid;
    logic       char_ready;

    modport master (output char, output char_valid, input  char_ready);
    modport slave  (input  char, input  char_valid, output char_ready);
endinterface

// File: rtl/id_gen_wrap_ctr.sv
// id_wrap_ctr: modulo-MOD counter with synchronous load.
//   clk, rst_n : clock, synchronous active-low reset (clears to 0)
//   load       : load load_val (reduced mod MOD) this cycle
//   load_val   : initial value, must be < 2*MOD
//   inc        : advance by one, wrapping MOD-1 -> 0
//   val        : registered count
//   nxt        : value val takes at the next edge (lets the parent
//                register outputs that depend on the new count)
module id_wrap_ctr #(
    parameter int W   = 5,
    parameter int MOD = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] val,
    output logic [W-1:0] nxt
);
    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    // Inputs are at most 2*MOD-1 wide in range, so one subtraction
    // is enough to reduce them.
    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = (load_val >= W'(MOD)) ? load_val - W'(MOD) : load_val;
        end else if (inc) begin
            val_d = (val_q == W'(MOD - 1)) ? '0 : val_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) val_q <= '0;
        else        val_q <= val_d;
    end

    assign val = val_q;
    assign nxt = val_d;
endmodule

// File: rtl/id_gen.sv
// id_gen: emits one identifier per request as a character stream:
//   n_alpha letters, n_digit digits, then the separator SEP.
//   clk, rst_n    : clock, synchronous active-low reset
//   start         : request pulse, honoured only in IDLE
//   n_alpha       : letter count (0 is rejected with err)
//   n_digit       : digit count (may be 0)
//   start_letter  : first letter index (mod 26), upper selects case
//   start_digit   : first digit (mod 10)
//   cs            : char / char_valid / char_ready stream (master)
//   busy          : request in progress
//   done          : one-cycle pulse after the separator is accepted
//   err           : one-cycle pulse on a rejected start
module id_gen
    import id_pkg::*;
#(
    parameter logic [7:0] SEP = CH_SP,
    parameter int         CW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] n_alpha,
    input  logic [CW-1:0] n_digit,
    input  logic [4:0]    start_letter,
    input  logic [3:0]    start_digit,
    input  logic          upper,
    id_gen_if.master      cs,
    output logic          busy,
    output logic          done,
    output logic          err
);
    state_e        state_q, state_d;
    logic [CW-1:0] alpha_cnt_q, alpha_cnt_d;
    logic [CW-1:0] digit_cnt_q, digit_cnt_d;
    logic          upper_q, upper_d;
    logic [7:0]    char_q, char_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          ctr_load, let_inc, dig_inc;
    logic [4:0]    let_val, let_nxt;
    logic [3:0]    dig_val, dig_nxt;
    logic          xfer;

    assign xfer = valid_q && cs.char_ready;

    id_wrap_ctr #(.W(5), .MOD(LETTERS)) u_let (
        .clk(clk), .rst_n(rst_n), .load(ctr_load), .load_val(start_letter),
        .inc(let_inc), .val(let_val), .nxt(let_nxt)
    );

    id_wrap_ctr #(.W(4), .MOD(DIGITS)) u_dig (
        .clk(clk), .rst_n(rst_n), .load(ctr_load), .load_val(start_digit),
        .inc(dig_inc), .val(dig_val), .nxt(dig_nxt)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alpha_cnt_q <= '0;
            digit_cnt_q <= '0;
            upper_q     <= 1'b0;
            char_q      <= 8'h00;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            alpha_cnt_q <= alpha_cnt_d;
            digit_cnt_q <= digit_cnt_d;
            upper_q     <= upper_d;
            char_q      <= char_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next state. Counters only move on a transfer, so a stall holds
    // everything that char is built from.
    always_comb begin
        state_d     = state_q;
        alpha_cnt_d = alpha_cnt_q;
        digit_cnt_d = digit_cnt_q;
        upper_d     = upper_q;
        ctr_load    = 1'b0;
        let_inc     = 1'b0;
        dig_inc     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (n_alpha == '0) begin
                    err_d = 1'b1;
                end else begin
                    state_d     = ALPHA;
                    alpha_cnt_d = n_alpha;
                    digit_cnt_d = n_digit;
                    upper_d     = upper;
                    ctr_load    = 1'b1;
                end
            end
            ALPHA: if (xfer) begin
                let_inc     = 1'b1;
                alpha_cnt_d = alpha_cnt_q - CW'(1);
                if (alpha_cnt_q == CW'(1))
                    state_d = (digit_cnt_q != '0) ? DIGIT : SEP_S;
            end
            DIGIT: if (xfer) begin
                dig_inc     = 1'b1;
                digit_cnt_d = digit_cnt_q - CW'(1);
                if (digit_cnt_q == CW'(1)) state_d = SEP_S;
            end
            SEP_S: if (xfer) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they can be
    // registered without adding a cycle of latency.
    always_comb begin
        valid_d = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        case (state_d)
            ALPHA:   char_d = (upper_d ? CH_A : CH_a) + 8'(let_nxt);
            DIGIT:   char_d = CH_0 + 8'(dig_nxt);
            SEP_S:   char_d = SEP;
            default: char_d = 8'h00;
        endcase
    end

    assign cs.char       = char_q;
    assign cs.char_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

    // Registered counter values are not needed outside the next-value path.
    logic unused_ok;
    assign unused_ok = ^{let_val, dig_val};
endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: expected characters are queued when a request
// is issued and popped as the stream transfers them.
module tb_id_gen;
    import id_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, start, upper, busy, done, err;
    logic [3:0] n_alpha, n_digit, start_digit;
    logic [4:0] start_letter;

    id_gen_if bus ();

    id_gen #(.SEP(8'h20), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_alpha(n_alpha),
        .n_digit(n_digit), .start_letter(start_letter), .start_digit(start_digit),
        .upper(upper), .cs(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0] sb[$];
    int n_assert = 0;
    int n_fail   = 0;
    int rec_ones = 0;
    bit rec_in   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic req(input int na, input int nd, input int sl, input int sd, input bit up);
        n_alpha      = 4'(na);
        n_digit      = 4'(nd);
        start_letter = 5'(sl);
        start_digit  = 4'(sd);
        upper        = up;
        start        = 1'b1;
    endtask

    // Runs one identifier to completion. Called at the negedge where start
    // has just been raised. Returns cycles with char_valid, the cycle index
    // of the first valid char and of done.
    task automatic run_id(input int stall_at, input int stall_len, input bit poke,
                          output int vcyc, output int first_c, output int done_c);
        int xfers   = 0;
        int stalled = 0;
        bit rdy;
        bit got_done = 0;
        bit got_err  = 0;
        vcyc = 0; first_c = -1; done_c = -1;
        for (int c = 0; c < 60 && !got_done; c++) begin
            @(negedge clk);
            rdy   = 1'b1;
            start = 1'b0;
            if (err) got_err = 1'b1;
            if (done) begin
                got_done = 1'b1;
                done_c   = c;
                chk("valid_after_done", bus.char_valid, 1'b0);
            end else begin
                if (poke && xfers == 2) begin
                    n_alpha = 4'd0;
                    start   = 1'b1;
                end
                if (bus.char_valid) begin
                    if (first_c < 0) first_c = c;
                    vcyc++;
                    chk("busy", busy, 1'b1);
                    if (xfers == stall_at && stalled < stall_len) begin
                        rdy = 1'b0;
                        stalled++;
                        chk("stall_hold", bus.char, (sb.size() != 0) ? sb[0] : 8'hxx);
                    end
                end
                bus.char_ready = rdy;
                if (bus.char_valid && rdy) begin
                    if (sb.size() == 0) chk("extra_char", bus.char, 8'hxx);
                    else chk("char", bus.char, sb.pop_front());
                    if ((bus.char >= 8'h61 && bus.char <= 8'h7A) ||
                        (bus.char >= 8'h41 && bus.char <= 8'h5A)) rec_in = 1'b1;
                    else if (bus.char >= 8'h30 && bus.char <= 8'h39 && rec_in) rec_ones++;
                    else rec_in = 1'b0;
                    xfers++;
                end
            end
        end
        start          = 1'b0;
        bus.char_ready = 1'b1;
        chk("done_seen", got_done, 1'b1);
        chk("no_err", got_err, 1'b0);
        chk("sb_empty", sb.size(), 0);
    endtask

    int vc, fc, dc;

    initial begin
        rst_n = 1'b0; start = 1'b0; upper = 1'b0; bus.char_ready = 1'b0;
        n_alpha = '0; n_digit = '0; start_letter = '0; start_digit = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.char_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_char", bus.char, 8'h00);
        rst_n = 1'b1;
        bus.char_ready = 1'b1;
        @(negedge clk);

        // "ab789 "
        sb = '{8'h61, 8'h62, 8'h37, 8'h38, 8'h39, 8'h20};
        req(2, 3, 0, 7, 1'b0);
        run_id(-1, 0, 1'b0, vc, fc, dc);
        chk("basic_latency", fc, 0);
        chk("basic_len", vc, 6);
        chk("basic_done_at", dc, fc + 6);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // Same identifier, 3-cycle stall on 'b', stray start mid-stream.
        sb = '{8'h61, 8'h62, 8'h37, 8'h38, 8'h39, 8'h20};
        req(2, 3, 0, 7, 1'b0);
        run_id(1, 3, 1'b1, vc, fc, dc);
        chk("stall_len", vc, 9);
        chk("stall_done_at", dc, fc + 9);
        @(negedge clk);

        // Out-of-range starts: letter 30 -> 'e', digit 13 -> '3'.
        sb = '{8'h65, 8'h33, 8'h34, 8'h20};
        req(1, 2, 30, 13, 1'b0);
        run_id(-1, 0, 1'b0, vc, fc, dc);
        chk("reduce_len", vc, 4);

        // Back-to-back: start raised in the done cycle. "YZA "
        sb = '{8'h59, 8'h5A, 8'h41, 8'h20};
        req(3, 0, 24, 0, 1'b1);
        run_id(-1, 0, 1'b0, vc, fc, dc);
        chk("wrap_latency", fc, 0);
        chk("wrap_len", vc, 4);

        // Reject n_alpha = 0.
        @(negedge clk);
        req(0, 2, 0, 0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("rej_err", err, 1'b1);
        chk("rej_busy", busy, 1'b0);
        chk("rej_valid", bus.char_valid, 1'b0);
        @(negedge clk);
        chk("rej_err_pulse", err, 1'b0);

        // Reset during DIGIT.
        req(1, 3, 0, 0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("mr_char_a", bus.char, 8'h61);
        @(negedge clk);
        chk("mr_char_0", bus.char, 8'h30);
        chk("mr_valid", bus.char_valid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_valid_off", bus.char_valid, 1'b0);
        chk("mr_no_done", done, 1'b0);
        chk("mr_busy", busy, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_quiet_done", done, 1'b0);
        end

        // "x12 " through the recognizer model.
        rec_ones = 0; rec_in = 1'b0;
        sb = '{8'h78, 8'h31, 8'h32, 8'h20};
        req(1, 2, 23, 1, 1'b0);
        run_id(-1, 0, 1'b0, vc, fc, dc);
        chk("loop_out_ones", rec_ones, 2);
        chk("loop_sep_reset", rec_in, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
